// File: rtl/memory_read_data_selector_if.sv
// rtl/memory_read_data_selector_if.sv - Fetch, R-channel and fragment stream bundle for the read data selector
interface memory_read_data_selector_if #(
  parameter int STREAM_WIDTH = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int ID_WIDTH     = 8,
  parameter int PIXEL_WIDTH  = 16
);
  logic                    s_fetch_axis_tvalid;
  logic                    s_fetch_axis_tlast;
  logic                    s_fetch_axis_tready;
  logic [ADDR_WIDTH-1:0]   s_fetch_axis_tdest;

  logic [ID_WIDTH-1:0]     s_mem_axi_rid;
  logic [STREAM_WIDTH-1:0] s_mem_axi_rdata;
  logic [1:0]              s_mem_axi_rresp;
  logic                    s_mem_axi_rlast;
  logic                    s_mem_axi_rvalid;
  logic                    s_mem_axi_rready;

  logic                    m_frag_axis_tvalid;
  logic                    m_frag_axis_tready;
  logic [PIXEL_WIDTH-1:0]  m_frag_axis_tdata;
  logic                    m_frag_axis_tlast;

  logic [1:0]              status_err;

  modport slave (
    input  s_fetch_axis_tvalid, s_fetch_axis_tlast, s_fetch_axis_tdest,
    output s_fetch_axis_tready,
    input  s_mem_axi_rid, s_mem_axi_rdata, s_mem_axi_rresp, s_mem_axi_rlast, s_mem_axi_rvalid,
    output s_mem_axi_rready,
    output m_frag_axis_tvalid, m_frag_axis_tdata, m_frag_axis_tlast,
    input  m_frag_axis_tready,
    output status_err
  );

  modport master (
    output s_fetch_axis_tvalid, s_fetch_axis_tlast, s_fetch_axis_tdest,
    input  s_fetch_axis_tready,
    output s_mem_axi_rid, s_mem_axi_rdata, s_mem_axi_rresp, s_mem_axi_rlast, s_mem_axi_rvalid,
    input  s_mem_axi_rready,
    input  m_frag_axis_tvalid, m_frag_axis_tdata, m_frag_axis_tlast,
    output m_frag_axis_tready,
    input  status_err
  );
endinterface

// File: rtl/memory_read_data_selector.sv
// rtl/memory_read_data_selector.sv - Pairs fetch requests with R beats and emits one selected pixel per fetch
// Optional RID sequence check enabled by defining MEMORY_READ_RID_CHECK_EN.
module memory_read_data_selector #(
  parameter int STREAM_WIDTH = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int ID_WIDTH     = 8,
  parameter int PIXEL_WIDTH  = 16
) (
  input  logic                         aclk,
  input  logic                         resetn,
  memory_read_data_selector_if.slave   bus
);
  localparam int LANES  = STREAM_WIDTH / PIXEL_WIDTH;
  localparam int IDX_W  = $clog2(LANES);
  localparam int IDX_WS = (IDX_W > 0) ? IDX_W : 1;
  localparam int TAG_W  = ADDR_WIDTH - IDX_W;

  typedef enum logic {ACCEPT, WAIT_R} state_t;

  state_t                               state, state_next;
  logic [TAG_W-1:0]                     last_tag;
  logic [LANES-1:0][PIXEL_WIDTH-1:0]    beat_buf;
  logic [LANES-1:0][PIXEL_WIDTH-1:0]    r_lanes;
  logic [IDX_WS-1:0]                    pend_idx;
  logic                                 pend_last;
  logic [IDX_WS-1:0]                    fetch_idx;
  logic [TAG_W-1:0]                     fetch_tag;
  logic                                 fetch_hit;
  logic                                 fetch_hs;
  logic                                 r_hs;
  logic                                 out_free;
  logic                                 fetch_tready;
  logic                                 rready;
  logic                                 tvalid_q;
  logic                                 tlast_q;
  logic [PIXEL_WIDTH-1:0]               tdata_q;
  logic                                 rresp_err;
  logic                                 rid_err;

  generate
    if (IDX_W > 0) begin : g_idx
      assign fetch_idx = bus.s_fetch_axis_tdest[IDX_W-1:0];
    end else begin : g_no_idx
      assign fetch_idx = '0;
    end
  endgenerate

  assign fetch_tag = bus.s_fetch_axis_tdest[ADDR_WIDTH-1:IDX_W];
  assign fetch_hit = (fetch_tag == last_tag);
  assign r_lanes   = bus.s_mem_axi_rdata;
  // The output slot is free when empty or being drained this cycle
  assign out_free  = !tvalid_q || bus.m_frag_axis_tready;
  assign fetch_hs  = bus.s_fetch_axis_tvalid && fetch_tready;
  assign r_hs      = bus.s_mem_axi_rvalid && rready;

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state <= ACCEPT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    fetch_tready = 1'b0;
    rready       = 1'b0;
    case (state)
      ACCEPT: begin
        fetch_tready = out_free;
        if (bus.s_fetch_axis_tvalid && out_free && !fetch_hit) begin
          state_next = WAIT_R;
        end
      end
      WAIT_R: begin
        rready = 1'b1;
        if (bus.s_mem_axi_rvalid) begin
          state_next = ACCEPT;
        end
      end
      default: state_next = ACCEPT;
    endcase
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      last_tag  <= '1;
      beat_buf  <= '0;
      pend_idx  <= '0;
      pend_last <= 1'b0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      tdata_q   <= '0;
      rresp_err <= 1'b0;
    end else begin
      // Tag tracking mirrors the address generator so beats and misses stay one-to-one
      if (fetch_hs) begin
        last_tag <= bus.s_fetch_axis_tlast ? '1 : fetch_tag;
        if (!fetch_hit) begin
          pend_idx  <= fetch_idx;
          pend_last <= bus.s_fetch_axis_tlast;
        end
      end
      if (r_hs) begin
        beat_buf <= r_lanes;
      end
      if (fetch_hs && fetch_hit) begin
        tvalid_q <= 1'b1;
        tdata_q  <= beat_buf[fetch_idx];
        tlast_q  <= bus.s_fetch_axis_tlast;
      end else if (r_hs) begin
        tvalid_q <= 1'b1;
        tdata_q  <= r_lanes[pend_idx];
        tlast_q  <= pend_last;
      end else if (bus.m_frag_axis_tready) begin
        tvalid_q <= 1'b0;
      end
      if (r_hs && (bus.s_mem_axi_rresp != 2'b00)) begin
        rresp_err <= 1'b1;
      end
    end
  end

`ifdef MEMORY_READ_RID_CHECK_EN
  logic [ID_WIDTH-1:0] exp_id;
  logic                unused_inputs;

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      exp_id  <= ID_WIDTH'(1);
      rid_err <= 1'b0;
    end else if (r_hs) begin
      exp_id <= exp_id + ID_WIDTH'(1);
      if (bus.s_mem_axi_rid != exp_id) begin
        rid_err <= 1'b1;
      end
    end
  end

  assign unused_inputs = bus.s_mem_axi_rlast;
`else
  logic unused_inputs;

  assign rid_err       = 1'b0;
  assign unused_inputs = ^{bus.s_mem_axi_rlast, bus.s_mem_axi_rid};
`endif

  assign bus.s_fetch_axis_tready = fetch_tready;
  assign bus.s_mem_axi_rready    = rready;
  assign bus.m_frag_axis_tvalid  = tvalid_q;
  assign bus.m_frag_axis_tdata   = tdata_q;
  assign bus.m_frag_axis_tlast   = tlast_q;
  assign bus.status_err          = {rid_err, rresp_err};
endmodule

// File: tb/tb_memory_read_data_selector.sv
// tb/tb_memory_read_data_selector.sv - Directed self-checking bench for memory_read_data_selector
module tb_memory_read_data_selector;
`ifdef MEMORY_READ_RID_CHECK_EN
  localparam logic [1:0] RID_ERR_EXP = 2'b10;
`else
  localparam logic [1:0] RID_ERR_EXP = 2'b00;
`endif

  logic aclk = 1'b0;
  logic resetn;
  always #5 aclk = ~aclk;

  memory_read_data_selector_if #(
    .STREAM_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(8), .PIXEL_WIDTH(16)
  ) bus ();

  memory_read_data_selector #(
    .STREAM_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(8), .PIXEL_WIDTH(16)
  ) dut (
    .aclk  (aclk),
    .resetn(resetn),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          r_hs_cnt = 0;
  int          r_base;
  logic [16:0] pix_q[$];

  always @(posedge aclk) begin
    if (resetn && bus.s_mem_axi_rvalid && bus.s_mem_axi_rready) r_hs_cnt <= r_hs_cnt + 1;
    if (resetn && bus.m_frag_axis_tvalid && bus.m_frag_axis_tready)
      pix_q.push_back({bus.m_frag_axis_tlast, bus.m_frag_axis_tdata});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_fetch(input logic [31:0] dest, input logic last);
    int n = 0;
    bus.s_fetch_axis_tvalid = 1'b1;
    bus.s_fetch_axis_tdest  = dest;
    bus.s_fetch_axis_tlast  = last;
    #1;
    while (!bus.s_fetch_axis_tready && n < 50) begin
      @(negedge aclk);
      #1;
      n++;
    end
    check("fetch_accept", 32'(bus.s_fetch_axis_tready), 32'd1);
    @(negedge aclk);
    bus.s_fetch_axis_tvalid = 1'b0;
    bus.s_fetch_axis_tlast  = 1'b0;
  endtask

  task automatic r_beat(input logic [31:0] d, input logic [1:0] resp, input logic [7:0] id);
    int n = 0;
    bus.s_mem_axi_rvalid = 1'b1;
    bus.s_mem_axi_rdata  = d;
    bus.s_mem_axi_rresp  = resp;
    bus.s_mem_axi_rid    = id;
    bus.s_mem_axi_rlast  = 1'b1;
    #1;
    while (!bus.s_mem_axi_rready && n < 50) begin
      @(negedge aclk);
      #1;
      n++;
    end
    check("r_accept", 32'(bus.s_mem_axi_rready), 32'd1);
    @(negedge aclk);
    bus.s_mem_axi_rvalid = 1'b0;
  endtask

  task automatic expect_pixel(input string tag, input logic [15:0] d, input logic l);
    int          n = 0;
    logic [16:0] v;
    while (pix_q.size() == 0 && n < 20) begin
      @(negedge aclk);
      n++;
    end
    check({tag, "_present"}, 32'(pix_q.size() > 0), 32'd1);
    if (pix_q.size() > 0) begin
      v = pix_q.pop_front();
      check(tag, {15'd0, v}, {15'd0, l, d});
    end
  endtask

  task automatic pulse_reset();
    resetn = 1'b0;
    bus.s_fetch_axis_tvalid = 1'b0;
    bus.s_mem_axi_rvalid    = 1'b0;
    repeat (2) @(negedge aclk);
    resetn = 1'b1;
    pix_q.delete();
    @(negedge aclk);
  endtask

  initial begin
    resetn = 1'b0;
    bus.s_fetch_axis_tvalid = 1'b0;
    bus.s_fetch_axis_tlast  = 1'b0;
    bus.s_fetch_axis_tdest  = '0;
    bus.s_mem_axi_rid       = '0;
    bus.s_mem_axi_rdata     = '0;
    bus.s_mem_axi_rresp     = 2'b00;
    bus.s_mem_axi_rlast     = 1'b0;
    bus.s_mem_axi_rvalid    = 1'b0;
    bus.m_frag_axis_tready  = 1'b0;
    repeat (2) @(negedge aclk);
    check("rst_tvalid", 32'(bus.m_frag_axis_tvalid), 32'd0);
    check("rst_tdata",  32'(bus.m_frag_axis_tdata),  32'd0);
    check("rst_tlast",  32'(bus.m_frag_axis_tlast),  32'd0);
    check("rst_rready", 32'(bus.s_mem_axi_rready),   32'd0);
    check("rst_err",    32'(bus.status_err),         32'd0);
    resetn = 1'b1;
    bus.m_frag_axis_tready = 1'b1;
    @(negedge aclk);

    // Two pixels of one beat, the second carrying tlast
    do_fetch(32'd0, 1'b0);
    check("rready_miss0", 32'(bus.s_mem_axi_rready), 32'd1);
    r_beat(32'hBBBB_AAAA, 2'b00, 8'd1);
    do_fetch(32'd1, 1'b1);
    expect_pixel("pix_aaaa", 16'hAAAA, 1'b0);
    expect_pixel("pix_bbbb", 16'hBBBB, 1'b1);
    check("r_count_1", 32'(r_hs_cnt), 32'd1);

    // tlast invalidated the tag, so the same dest needs a fresh beat
    do_fetch(32'd1, 1'b0);
    check("rready_after_tlast", 32'(bus.s_mem_axi_rready), 32'd1);
    r_beat(32'h2222_1111, 2'b00, 8'd2);
    expect_pixel("pix_2222", 16'h2222, 1'b0);
    check("r_count_2", 32'(r_hs_cnt), 32'd2);

    // Backpressure: output held, fetch and R both stalled
    bus.m_frag_axis_tready = 1'b0;
    do_fetch(32'd4, 1'b0);
    r_beat(32'h0000_CAFE, 2'b00, 8'd3);
    bus.s_fetch_axis_tvalid = 1'b1;
    bus.s_fetch_axis_tdest  = 32'd6;
    bus.s_mem_axi_rvalid    = 1'b1;
    bus.s_mem_axi_rdata     = 32'h0000_BEEF;
    bus.s_mem_axi_rid       = 8'd4;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check("stall_tvalid", 32'(bus.m_frag_axis_tvalid),  32'd1);
      check("stall_tdata",  32'(bus.m_frag_axis_tdata),   32'h0000_CAFE);
      check("stall_ftready", 32'(bus.s_fetch_axis_tready), 32'd0);
      check("stall_rready", 32'(bus.s_mem_axi_rready),    32'd0);
    end
    check("stall_r_count", 32'(r_hs_cnt), 32'd3);
    bus.m_frag_axis_tready = 1'b1;
    do_fetch(32'd6, 1'b0);
    r_beat(32'h0000_BEEF, 2'b00, 8'd4);
    expect_pixel("pix_cafe", 16'hCAFE, 1'b0);
    expect_pixel("pix_beef", 16'hBEEF, 1'b0);
    check("r_count_4", 32'(r_hs_cnt), 32'd4);

    // Error response still yields a pixel; the flag is sticky
    do_fetch(32'd8, 1'b0);
    r_beat(32'h5555_3333, 2'b10, 8'd5);
    expect_pixel("pix_rresp", 16'h3333, 1'b0);
    check("err_rresp", 32'(bus.status_err), 32'd1);
    do_fetch(32'd10, 1'b0);
    r_beat(32'h0000_7777, 2'b00, 8'd6);
    expect_pixel("pix_7777", 16'h7777, 1'b0);
    check("err_sticky", 32'(bus.status_err), 32'd1);

    // Reset while waiting for a beat
    do_fetch(32'd12, 1'b0);
    check("rready_pre_rst", 32'(bus.s_mem_axi_rready), 32'd1);
    resetn = 1'b0;
    #1;
    check("midrst_rready", 32'(bus.s_mem_axi_rready),   32'd0);
    check("midrst_tvalid", 32'(bus.m_frag_axis_tvalid), 32'd0);
    check("midrst_err",    32'(bus.status_err),         32'd0);
    @(negedge aclk);
    resetn = 1'b1;
    pix_q.delete();
    @(negedge aclk);
    r_base = r_hs_cnt;
    do_fetch(32'd0, 1'b0);
    check("rready_post_rst", 32'(bus.s_mem_axi_rready), 32'd1);
    r_beat(32'h4444_3333, 2'b00, 8'd1);
    do_fetch(32'd1, 1'b0);
    expect_pixel("pix_post0", 16'h3333, 1'b0);
    expect_pixel("pix_post1", 16'h4444, 1'b0);
    check("r_count_post", 32'(r_hs_cnt - r_base), 32'd1);

    // RID sequence 1, 2, 5
    pulse_reset();
    do_fetch(32'd20, 1'b0);
    r_beat(32'h0001_0002, 2'b00, 8'd1);
    expect_pixel("pix_rid1", 16'h0002, 1'b0);
    check("rid_err_1", 32'(bus.status_err), 32'd0);
    do_fetch(32'd22, 1'b0);
    r_beat(32'h0003_0004, 2'b00, 8'd2);
    expect_pixel("pix_rid2", 16'h0004, 1'b0);
    check("rid_err_2", 32'(bus.status_err), 32'd0);
    do_fetch(32'd24, 1'b0);
    r_beat(32'h0005_0006, 2'b00, 8'd5);
    expect_pixel("pix_rid5", 16'h0006, 1'b0);
    check("rid_err_5", 32'(bus.status_err), 32'(RID_ERR_EXP));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
